// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    localparam logic [3:0] SEQ_DET_RST_PAT = 4'b1011;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    // Width needed to count 0..pat_w accepted bits.
    function automatic int unsigned fill_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_prog_if.sv
// Serial bit stream, pattern load and match result bundle for seq_det_prog.
interface seq_det_prog_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             din;
    logic             din_valid;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             y;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output din, din_valid, overlap, pat_load, pat_in,
        input  y, match_cnt
    );

    modport slave (
        input  din, din_valid, overlap, pat_load, pat_in,
        output y, match_cnt
    );
endinterface

// File: rtl/seq_det_hist.sv
// Bit history shift register plus saturating fill counter; exposes the
// post-accept view (next history, next-full) so the compare sees the new bit.
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             din,
    input  logic             clr,
    output logic [PAT_W-1:0] hist_nxt_c,
    output logic             full_nxt_c
);
    localparam int unsigned FILL_W = fill_w(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt_c;

    // Oldest bit falls off the top as the new one enters at the LSB.
    assign hist_nxt_c = PAT_W'({hist, din});
    assign fill_nxt_c = (fill == FILL_MAX) ? fill : fill + 1'b1;
    assign full_nxt_c = (fill_nxt_c == FILL_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else begin
            if (shift) begin
                hist <= hist_nxt_c;
            end
            // A clear wins over a shift: the shifted bit is kept but not counted.
            if (clr) begin
                fill <= '0;
            end else if (shift) begin
                fill <= fill_nxt_c;
            end
        end
    end

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector with registered Moore match output.
// Optional saturating match counter enabled by defining SEQ_DET_MATCH_CNT_EN.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(SEQ_DET_RST_PAT),
    parameter int unsigned      CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_det_prog_if.slave  bus
);
    logic [PAT_W-1:0] pattern;
    logic [PAT_W-1:0] hist_nxt_c;
    logic             full_nxt_c;
    logic             accept_c;
    logic             match_c;
    logic             fill_clr_c;
    logic             y_q;

    assign accept_c   = bus.din_valid & ~bus.pat_load;
    assign match_c    = accept_c & full_nxt_c & (hist_nxt_c == pattern);
    assign fill_clr_c = bus.pat_load | (match_c & (bus.overlap == OVL_OFF));

    seq_det_hist #(
        .PAT_W (PAT_W)
    ) u_hist (
        .clk        (clk),
        .rst        (rst),
        .shift      (accept_c),
        .din        (bus.din),
        .clr        (fill_clr_c),
        .hist_nxt_c (hist_nxt_c),
        .full_nxt_c (full_nxt_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= RST_PAT;
        end else if (bus.pat_load) begin
            pattern <= bus.pat_in;
        end
    end

    // y only moves on an accepted bit or a pattern reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= 1'b0;
        end else if (bus.pat_load) begin
            y_q <= 1'b0;
        end else if (accept_c) begin
            y_q <= match_c;
        end
    end

    assign bus.y = y_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.pat_load) begin
            cnt_q <= '0;
        end else if (match_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Scoreboard bench for seq_det_prog; counter expectations follow SEQ_DET_MATCH_CNT_EN.
module tb_seq_det_prog;

`ifdef SEQ_DET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_det_prog_if #(.PAT_W(4), .CNT_W(8)) bus ();
    seq_det_prog_if #(.PAT_W(4), .CNT_W(2)) sbus ();

    seq_det_prog #(.PAT_W(4), .RST_PAT(4'b1011), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    seq_det_prog #(.PAT_W(4), .RST_PAT(4'b1111), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    typedef struct packed {
        logic       y;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: the bits seen since the last clear, newest at the back.
    bit       m_q[$];
    logic [3:0] m_pat;
    logic     m_y;
    int       m_cnt;

    task automatic do_rst();
        rst = 1'b1;
        bus.din_valid = 1'b0;
        bus.pat_load  = 1'b0;
        sbus.din_valid = 1'b0;
        sbus.pat_load  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_q.delete();
        m_pat = 4'b1011;
        m_y   = 1'b0;
        m_cnt = 0;
    endtask

    task automatic step(input logic d, input logic v, input logic ld,
                        input logic ovl, input logic [3:0] p);
        bit         match;
        logic [3:0] w;
        exp_t       x;
        bus.din       = d;
        bus.din_valid = v;
        bus.pat_load  = ld;
        bus.overlap   = ovl;
        bus.pat_in    = p;
        if (ld) begin
            m_pat = p;
            m_q.delete();
            m_y   = 1'b0;
            m_cnt = 0;
        end else if (v) begin
            m_q.push_back(d);
            if (m_q.size() > 4) void'(m_q.pop_front());
            match = 1'b0;
            if (m_q.size() == 4) begin
                w = {m_q[0], m_q[1], m_q[2], m_q[3]};
                match = (w == m_pat);
            end
            m_y = match;
            if (match) begin
                if (m_cnt < 255) m_cnt++;
                if (!ovl) m_q.delete();
            end
        end
        x.y   = m_y;
        x.cnt = CNT_EN ? 8'(m_cnt) : 8'd0;
        sb.push_back(x);
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        bus.pat_load  = 1'b0;
    endtask

    task automatic test_reset();
        bus.din = 1'b0; bus.overlap = 1'b0; bus.pat_in = 4'h0;
        sbus.din = 1'b0; sbus.overlap = 1'b0; sbus.pat_in = 4'h0;
        do_rst();
        do_rst();
        n_chk++;
        if ({bus.y, bus.match_cnt} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset: y=%b cnt=%0d, required y=0 cnt=0", bus.y, bus.match_cnt);
        end
        n_chk++;
        if ({sbus.y, sbus.match_cnt} !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_sat: y=%b cnt=%0d, required y=0 cnt=0", sbus.y, sbus.match_cnt);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s   = 7'b1011011;
        logic [6:0] ey  = 7'b0001001;
        do_rst();
        for (int i = 6; i >= 0; i--) begin
            step(s[i], 1'b1, 1'b0, 1'b1, 4'h0);
            e = sb.pop_front();
            n_chk++;
            if ({bus.y, bus.match_cnt} !== {e.y, e.cnt} || bus.y !== ey[i]) begin
                n_fail++;
                $display("FAIL overlap[%0d]: y=%b cnt=%0d, required y=%b cnt=%0d",
                         6 - i, bus.y, bus.match_cnt, ey[i], e.cnt);
            end
        end
        n_chk++;
        if (bus.match_cnt !== (CNT_EN ? 8'd2 : 8'd0)) begin
            n_fail++;
            $display("FAIL overlap_cnt: cnt=%0d, required %0d", bus.match_cnt, CNT_EN ? 2 : 0);
        end
    endtask

    task automatic test_non_overlap();
        logic [9:0] s  = 10'b1011011011;
        logic [9:0] ey = 10'b0001000001;
        do_rst();
        for (int i = 9; i >= 0; i--) begin
            step(s[i], 1'b1, 1'b0, 1'b0, 4'h0);
            e = sb.pop_front();
            n_chk++;
            if ({bus.y, bus.match_cnt} !== {e.y, e.cnt} || bus.y !== ey[i]) begin
                n_fail++;
                $display("FAIL non_overlap[%0d]: y=%b cnt=%0d, required y=%b cnt=%0d",
                         9 - i, bus.y, bus.match_cnt, ey[i], e.cnt);
            end
        end
    endtask

    task automatic test_gapped();
        logic [3:0] s = 4'b1011;
        do_rst();
        for (int i = 3; i >= 0; i--) begin
            for (int g = 0; g < 4; g++) begin
                if (g == 0) step(s[i], 1'b1, 1'b0, 1'b0, 4'h0);
                else        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
                e = sb.pop_front();
                n_chk++;
                if ({bus.y, bus.match_cnt} !== {e.y, e.cnt}) begin
                    n_fail++;
                    $display("FAIL gapped[%0d.%0d]: y=%b cnt=%0d, required y=%b cnt=%0d",
                             3 - i, g, bus.y, bus.match_cnt, e.y, e.cnt);
                end
            end
        end
        n_chk++;
        if (bus.y !== 1'b1) begin
            n_fail++;
            $display("FAIL gapped_hold: y=%b, required 1", bus.y);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        e = sb.pop_front();
        n_chk++;
        if (bus.y !== 1'b0 || e.y !== 1'b0) begin
            n_fail++;
            $display("FAIL gapped_clear: y=%b, required 0", bus.y);
        end
    endtask

    task automatic test_reload();
        logic [5:0] s = 6'b100110;
        do_rst();
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
        void'(sb.pop_front());
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
        void'(sb.pop_front());
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
        e = sb.pop_front();
        n_chk++;
        if ({bus.y, bus.match_cnt} !== 9'd0) begin
            n_fail++;
            $display("FAIL reload_load: y=%b cnt=%0d, required y=0 cnt=0", bus.y, bus.match_cnt);
        end
        for (int i = 3; i >= 0; i--) begin
            step(s[i], 1'b1, 1'b0, 1'b1, 4'h0);
            e = sb.pop_front();
            n_chk++;
            if ({bus.y, bus.match_cnt} !== {e.y, e.cnt} || bus.y !== (i == 0)) begin
                n_fail++;
                $display("FAIL reload[%0d]: y=%b cnt=%0d, required y=%b cnt=%0d",
                         3 - i, bus.y, bus.match_cnt, e.y, e.cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] s = 4'b1011;
        do_rst();
        for (int i = 3; i >= 1; i--) begin
            step(s[i], 1'b1, 1'b0, 1'b1, 4'h0);
            void'(sb.pop_front());
        end
        do_rst();
        for (int i = 3; i >= 0; i--) begin
            step(s[i], 1'b1, 1'b0, 1'b1, 4'h0);
            e = sb.pop_front();
            n_chk++;
            if ({bus.y, bus.match_cnt} !== {e.y, e.cnt} || bus.y !== (i == 0)) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: y=%b cnt=%0d, required y=%b cnt=%0d",
                         3 - i, bus.y, bus.match_cnt, e.y, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_rst();
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
        void'(sb.pop_front());
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 1'b1, 1'b0, (i < 6) ? 1'b1 : 1'b0, 4'h0);
            e = sb.pop_front();
            n_chk++;
            if ({bus.y, bus.match_cnt} !== {e.y, e.cnt}) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: y=%b cnt=%0d, required y=%b cnt=%0d",
                         i, bus.y, bus.match_cnt, e.y, e.cnt);
            end
        end
    endtask

    task automatic test_random();
        logic d, v, ld, ovl;
        logic [3:0] p;
        do_rst();
        for (int i = 0; i < 150; i++) begin
            d   = 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 19) == 0);
            ovl = 1'($urandom_range(0, 1));
            p   = 4'($urandom_range(0, 15));
            step(d, v, ld, ovl, p);
            e = sb.pop_front();
            n_chk++;
            if ({bus.y, bus.match_cnt} !== {e.y, e.cnt}) begin
                n_fail++;
                $display("FAIL random[%0d]: y=%b cnt=%0d, required y=%b cnt=%0d",
                         i, bus.y, bus.match_cnt, e.y, e.cnt);
            end
        end
    endtask

    task automatic test_saturation();
        logic [2:0] x;
        do_rst();
        for (int k = 1; k <= 10; k++) begin
            sbus.din       = 1'b1;
            sbus.din_valid = 1'b1;
            sbus.overlap   = 1'b1;
            x[2]   = (k >= 4);
            x[1:0] = (CNT_EN && k >= 4) ? 2'((k - 3 > 3) ? 3 : k - 3) : 2'd0;
            @(posedge clk);
            #1;
            n_chk++;
            if ({sbus.y, sbus.match_cnt} !== x) begin
                n_fail++;
                $display("FAIL saturation[%0d]: y=%b cnt=%0d, required y=%b cnt=%0d",
                         k, sbus.y, sbus.match_cnt, x[2], x[1:0]);
            end
        end
        sbus.din_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gapped();
        test_reload();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
